ltc2315_responder: RTL and testbench
====================================

LTC2315_RESPONDER -- requirements
Module: ltc2315_responder

Purpose: synthesizable LTC2315 ADC-side model (SPI responder). It answers the adc_ltc2315 master on a loopback or test board so ADC→FIFO→Ethernet paths run without a real converter.

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12: converter resolution in bits.
REQ-002 The block SHALL have parameter FRAME_SCK, default 16: SCK falling edges per full frame.
REQ-003 The block SHALL have parameter RAMP_STEP, default 1: ramp increment per completed frame.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  system clock; at least 4x the SCK frequency.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have these SPI ports:
- cs  in  1  chip select from the master, asynchronous to clk, active-low frame.
- sck  in  1  serial clock from the master, asynchronous to clk.
- sdo  out  1  serial data to the master.
- sdo_oe  out  1  output enable; 0 models high-Z.
REQ-006 The block SHALL have these control ports:
- mode  in  2  sample source: 0 constant, 1 ramp, 2 external, 3 reserved (treated as constant).
- const_val  in  DATA_W  value used in constant mode.
- ext_data  in  DATA_W  sample used in external mode.
- ext_valid  in  1  one-cycle strobe that latches ext_data.
REQ-007 The block SHALL have these status ports:
- frame_done  out  1  one-cycle pulse when a full frame completes.
- short_frame  out  1  one-cycle pulse when cs rises before FRAME_SCK SCK falls.
- frame_cnt  out  16  count of completed full frames, wrapping.

Function
REQ-008 cs and sck SHALL each pass through a 2-flop synchronizer plus an edge detector; all internal actions SHALL occur 3 clk cycles after the pin edge.
REQ-009 States SHALL be IDLE and SHIFT.
REQ-010 In IDLE, a detected cs fall SHALL cause these actions:
- load the shift register with {1'b0, sample[DATA_W-1:0], zero padding} to FRAME_SCK bits;
- drive sdo = leading 0 and sdo_oe = 1;
- clear the bit counter;
- enter SHIFT.
REQ-011 In SHIFT, each detected sck fall SHALL shift the register left by one, present the new MSB on sdo, and increment the bit counter.
REQ-012 Data SHALL be MSB-first; the bit on sdo after the k-th sck fall SHALL be frame bit k (k=0 being the leading zero presented at cs fall).
REQ-013 SCK falls beyond FRAME_SCK within one frame SHALL shift in zeros; sdo SHALL stay 0 and the counter SHALL saturate.
REQ-014 A detected cs rise in SHIFT with counter ≥ FRAME_SCK SHALL cause these actions:
- pulse frame_done;
- increment frame_cnt;
- advance the ramp;
- go to IDLE with sdo_oe = 0 and sdo = 0.
REQ-015 A detected cs rise in SHIFT with counter < FRAME_SCK SHALL pulse short_frame and return to IDLE; frame_cnt and the ramp SHALL NOT change.
REQ-016 Simultaneous cs rise and sck fall in the same clk cycle SHALL apply the sck shift before evaluating the counter.
REQ-017 The ramp register SHALL be DATA_W bits, advance by RAMP_STEP modulo 2^DATA_W, and wrap 4095→0 at DATA_W=12.
REQ-018 The sample SHALL be selected at cs fall only; changes to mode, const_val or ext_data mid-frame SHALL affect the next frame only.
REQ-019 ext_valid SHALL latch ext_data into an internal hold register; the hold register, not ext_data directly, SHALL be used in external mode.
REQ-020 A cs fall detected while in SHIFT is impossible after a rise and SHALL be ignored.
REQ-021 sck edges while in IDLE SHALL be ignored.

Reset
REQ-022 While rst_n = 0 the following SHALL hold:
- state IDLE;
- sdo = 0 and sdo_oe = 0;
- frame_done = 0 and short_frame = 0;
- frame_cnt = 0;
- ramp = 0;
- ext hold = 0;
- synchronizers set to cs = 1 and sck = 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame without pulsing frame_done or short_frame.
REQ-024 After deassertion the block SHALL wait for a fresh cs fall.

Structure
REQ-025 Package ltc2315_pkg SHALL hold the mode encoding (MODE_CONST, MODE_RAMP, MODE_EXT), the state encoding, and the default DATA_W and FRAME_SCK constants.
REQ-026 A sub-module sync_edge (2-flop synchronizer, rise/fall pulses, reset value as a parameter) SHALL be instantiated twice, once for cs and once for sck.

Verification
REQ-027 The bench SHALL cover these scenarios:
- Ramp: mode=1, master runs 3 frames of 16 sck → words 0x000, 0x001, 0x002 are read; frame_cnt = 3; three frame_done pulses.
- Constant: mode=0, const_val=0xABC → each bit on sdo matches {0, 0xABC, 000}; sdo_oe = 0 between frames.
- Short frame: cs rises after 8 sck → short_frame pulse, frame_cnt unchanged; the next full frame returns the same ramp value.
- Wrap: ramp preset to 0xFFF via 4095 frames (or a forced start) → next frame reads 0x000.
- External timing: ext_valid with 0x123 mid-frame → current frame keeps its old value; next frame reads 0x123.
- Reset mid-frame: rst_n low after 5 sck → sdo_oe = 0, frame_cnt = 0, no pulses; next frame reads 0x000 in ramp mode.

Source files
------------

// File: rtl/ltc2315_pkg.sv
// Shared encodings and default geometry for the LTC2315 responder model.
package ltc2315_pkg;

    // Default converter resolution and frame length in SCK falling edges.
    localparam int DEF_DATA_W    = 12;
    localparam int DEF_FRAME_SCK = 16;

    // Sample source selection; the reserved code behaves like constant.
    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_EXT   = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    // Responder frame state.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus rise/fall pulse detection.
// Pulses are one clk wide and appear two clk edges after the pin changes, so a
// registered consumer acts on the third edge.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ltc2315_responder.sv
// LTC2315 ADC-side SPI responder: presents a leading zero, then the selected
// sample MSB-first, then zero padding, one bit per SCK falling edge.
module ltc2315_responder
    import ltc2315_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_SCK = DEF_FRAME_SCK,
    parameter int RAMP_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              sck,
    output logic              sdo,
    output logic              sdo_oe,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_valid,
    output logic              frame_done,
    output logic              short_frame,
    output logic [15:0]       frame_cnt
);

    localparam int                CNT_W   = $clog2(FRAME_SCK + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FRAME_SCK);
    localparam int                PAD_W   = FRAME_SCK - 1 - DATA_W;

    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sck_fall;
    logic w_unused_sck_rise;

    state_e                r_state;
    logic [FRAME_SCK-1:0]  r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_oe;
    logic                  r_frame_done;
    logic                  r_short_frame;
    logic [15:0]           r_frame_cnt;
    logic [DATA_W-1:0]     r_ramp;
    logic [DATA_W-1:0]     r_ext_hold;

    state_e                w_nxt_state;
    logic [FRAME_SCK-1:0]  w_nxt_shift;
    logic [CNT_W-1:0]      w_nxt_cnt;
    logic                  w_nxt_oe;
    logic                  w_nxt_frame_done;
    logic                  w_nxt_short_frame;
    logic [15:0]           w_nxt_frame_cnt;
    logic [DATA_W-1:0]     w_nxt_ramp;
    logic [DATA_W-1:0]     w_sample;

    // cs idles high, sck idles low.
    sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (cs),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (sck),
        .o_rise (w_unused_sck_rise),
        .o_fall (w_sck_fall)
    );

    // Sample source mux; only consulted when a frame starts.
    always_comb begin
        w_sample = const_val;
        case (mode_e'(mode))
            MODE_CONST: w_sample = const_val;
            MODE_RAMP:  w_sample = r_ramp;
            MODE_EXT:   w_sample = r_ext_hold;
            default:    w_sample = const_val;
        endcase
    end

    // Frame FSM next-state and next-value logic.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_shift       = r_shift;
        w_nxt_cnt         = r_cnt;
        w_nxt_oe          = r_oe;
        w_nxt_frame_done  = 1'b0;
        w_nxt_short_frame = 1'b0;
        w_nxt_frame_cnt   = r_frame_cnt;
        w_nxt_ramp        = r_ramp;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    // Leading zero lands in the MSB because the sample is
                    // zero-extended before being shifted into place.
                    w_nxt_shift = FRAME_SCK'(w_sample) << PAD_W;
                    w_nxt_cnt   = '0;
                    w_nxt_oe    = 1'b1;
                    w_nxt_state = ST_SHIFT;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The shift is applied first so a coincident cs rise sees
                // the updated count.
                if (w_sck_fall) begin
                    w_nxt_shift = {r_shift[FRAME_SCK-2:0], 1'b0};
                    if (r_cnt < CNT_MAX) begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end else begin
                        w_nxt_cnt = r_cnt;
                    end
                end else begin
                    w_nxt_shift = r_shift;
                end
                if (w_cs_rise) begin
                    if (w_nxt_cnt >= CNT_MAX) begin
                        w_nxt_frame_done = 1'b1;
                        w_nxt_frame_cnt  = r_frame_cnt + 16'd1;
                        w_nxt_ramp       = r_ramp + DATA_W'(RAMP_STEP);
                    end else begin
                        w_nxt_short_frame = 1'b1;
                    end
                    w_nxt_shift = '0;
                    w_nxt_oe    = 1'b0;
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_state = ST_SHIFT;
                end
            end
            default: begin
                w_nxt_shift = '0;
                w_nxt_oe    = 1'b0;
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_oe          <= 1'b0;
            r_frame_done  <= 1'b0;
            r_short_frame <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_ramp        <= '0;
        end else begin
            r_state       <= w_nxt_state;
            r_shift       <= w_nxt_shift;
            r_cnt         <= w_nxt_cnt;
            r_oe          <= w_nxt_oe;
            r_frame_done  <= w_nxt_frame_done;
            r_short_frame <= w_nxt_short_frame;
            r_frame_cnt   <= w_nxt_frame_cnt;
            r_ramp        <= w_nxt_ramp;
        end
    end

    // External sample hold, captured on the strobe regardless of frame state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_hold <= '0;
        end else if (ext_valid) begin
            r_ext_hold <= ext_data;
        end else begin
            r_ext_hold <= r_ext_hold;
        end
    end

    assign sdo         = r_shift[FRAME_SCK-1];
    assign sdo_oe      = r_oe;
    assign frame_done  = r_frame_done;
    assign short_frame = r_short_frame;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_ltc2315_responder.sv
module tb_ltc2315_responder;

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic        sck;
    logic        sdo;
    logic        sdo_oe;
    logic [1:0]  mode;
    logic [11:0] const_val;
    logic [11:0] ext_data;
    logic        ext_valid;
    logic        frame_done;
    logic        short_frame;
    logic [15:0] frame_cnt;

    int n_checks;
    int n_errors;
    int n_done;
    int n_short;

    logic [15:0] word;
    logic        extra;
    logic        oe_seen;

    ltc2315_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .sck         (sck),
        .sdo         (sdo),
        .sdo_oe      (sdo_oe),
        .mode        (mode),
        .const_val   (const_val),
        .ext_data    (ext_data),
        .ext_valid   (ext_valid),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count status pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_done)  n_done++;
        if (short_frame) n_short++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master frame: nsck falls; optional ext strobe after fall ext_at, optional
    // reset after fall abort_at, optional cs rise coincident with last fall.
    task automatic run_frame(input int nsck, input int ext_at, input logic [11:0] ext_val,
                             input int abort_at, input logic merge,
                             output logic [15:0] bits, output logic xtra, output logic oe);
        bits = 16'h0;
        xtra = 1'b0;
        cs = 1'b0;
        wait_clk(6);
        bits[15] = sdo;
        oe = sdo_oe;
        for (int k = 1; k <= nsck; k++) begin
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
            if (merge && k == nsck) cs = 1'b1;
            wait_clk(5);
            if (k < 16) bits[15-k] = sdo;
            else xtra = xtra | sdo;
            if (k == ext_at) begin
                ext_data  = ext_val;
                ext_valid = 1'b1;
                wait_clk(1);
                ext_valid = 1'b0;
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                wait_clk(3);
                return;
            end
        end
        cs = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        int d0;
        int s0;
        n_checks = 0; n_errors = 0; n_done = 0; n_short = 0;
        rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mode = 2'd1;
        const_val = 12'h000; ext_data = 12'h000; ext_valid = 1'b0;
        wait_clk(4);
        check("rst_sdo", {31'd0, sdo}, 32'd0);
        check("rst_oe", {31'd0, sdo_oe}, 32'd0);
        check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_pulses", n_done + n_short, 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // Ramp: three full frames.
        run_frame(16, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("ramp0_word", {16'd0, word}, 32'h0000);
        check("ramp0_oe", {31'd0, oe_seen}, 32'd1);
        check("ramp0_oe_idle", {31'd0, sdo_oe}, 32'd0);
        run_frame(16, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("ramp1_word", {16'd0, word}, 32'h0008);
        run_frame(16, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("ramp2_word", {16'd0, word}, 32'h0010);
        check("ramp_cnt", {16'd0, frame_cnt}, 32'd3);
        check("ramp_done", n_done, 32'd3);

        // Short frame leaves count and ramp alone.
        run_frame(8, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("short_pulse", n_short, 32'd1);
        check("short_cnt", {16'd0, frame_cnt}, 32'd3);
        check("short_done", n_done, 32'd3);
        run_frame(16, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("after_short_word", {16'd0, word}, 32'h0018);

        // Constant mode, 0xABC.
        mode = 2'd0; const_val = 12'hABC;
        run_frame(16, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("const_word", {16'd0, word}, 32'h55E0);
        check("const_oe_idle", {31'd0, sdo_oe}, 32'd0);
        check("const_sdo_idle", {31'd0, sdo}, 32'd0);
        // Reserved mode behaves as constant; cs rise coincident with 16th fall.
        mode = 2'd3;
        d0 = n_done;
        run_frame(16, 0, 12'h0, 0, 1'b1, word, extra, oe_seen);
        check("rsvd_word", {16'd0, word}, 32'h55E0);
        check("merge_done", n_done - d0, 32'd1);
        check("merge_cnt", {16'd0, frame_cnt}, 32'd6);

        // External: hold updated mid-frame applies to the next frame only.
        mode = 2'd2;
        ext_data = 12'h456; ext_valid = 1'b1; wait_clk(1); ext_valid = 1'b0;
        ext_data = 12'h789;
        run_frame(16, 5, 12'h123, 0, 1'b0, word, extra, oe_seen);
        check("ext_old_word", {16'd0, word}, {16'd0, 1'b0, 12'h456, 3'b000});
        ext_data = 12'hFFF;
        run_frame(16, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("ext_new_word", {16'd0, word}, {16'd0, 1'b0, 12'h123, 3'b000});

        // Ramp wrap from a forced start at 0xFFF.
        mode = 2'd1;
        force dut.r_ramp = 12'hFFF;
        wait_clk(1);
        release dut.r_ramp;
        wait_clk(1);
        run_frame(16, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("wrap_fff_word", {16'd0, word}, 32'h7FF8);
        run_frame(16, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("wrap_000_word", {16'd0, word}, 32'h0000);
        check("wrap_cnt", {16'd0, frame_cnt}, 32'd10);

        // Reset mid-frame after 5 falls.
        d0 = n_done; s0 = n_short;
        run_frame(16, 0, 12'h0, 5, 1'b0, word, extra, oe_seen);
        check("rstmid_oe", {31'd0, sdo_oe}, 32'd0);
        check("rstmid_sdo", {31'd0, sdo}, 32'd0);
        check("rstmid_cnt", {16'd0, frame_cnt}, 32'd0);
        cs = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(6);
        check("rstmid_pulses", (n_done - d0) + (n_short - s0), 32'd0);
        run_frame(16, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("rstmid_next_word", {16'd0, word}, 32'h0000);

        // Overlong frame: extra falls shift zeros, still a full frame.
        run_frame(20, 0, 12'h0, 0, 1'b0, word, extra, oe_seen);
        check("long_word", {16'd0, word}, 32'h0008);
        check("long_extra", {31'd0, extra}, 32'd0);
        check("long_cnt", {16'd0, frame_cnt}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
